// File: rtl/apb_cmd_master_pkg.sv
// rtl/apb_cmd_master_pkg.sv - shared types and constants for the APB command master
package apb_cmd_master_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int PROT_W      = 3;
    localparam int TMO_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command/response and APB signal bundle for apb_cmd_master
interface apb_cmd_master_if;
    import apb_cmd_master_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [PROT_W-1:0] cmd_prot;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [PROT_W-1:0] pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // master: the command master itself; slave: requester plus APB responder
    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
        input  rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output psel, penable, pwrite, paddr, pwdata, pprot
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_prot,
        output rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  psel, penable, pwrite, paddr, pwdata, pprot
    );

endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding command to APB transfer master with wait-state timeout
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int TMO_W   = 8
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic [PROT_W-1:0] pprot_q, pprot_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;

    // Strobes decode straight from the state so reset drops psel asynchronously.
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.penable   = (state_q == ST_ACCESS);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pprot     = pprot_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_tmo   = tmo_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            pprot_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            pprot_q  <= pprot_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        pprot_d  = pprot_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    pwrite_d = bus.cmd_write;
                    pprot_d  = bus.cmd_prot;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over the timeout in the threshold cycle
                if (bus.pready) begin
                    rdata_d = pwrite_q ? '0 : bus.prdata;
                    err_d   = bus.pslverr;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TMO_W'(TMO_CYC - 1)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
    import apb_cmd_master_pkg::*;

    logic pclk;
    logic preset;
    int   tests;
    int   fails;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.TMO_CYC(4), .TMO_W(8)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    logic              prev_psel;
    logic [ADDR_W-1:0] prev_paddr;
    logic [DATA_W-1:0] prev_pwdata;
    logic              prev_pwrite;
    logic [PROT_W-1:0] prev_pprot;

    always @(negedge pclk) begin
        if (!preset) begin
            if (bus.psel && !prev_psel) chk("proto_psel_rise_penable", 32'(bus.penable), 32'd0);
            if (bus.penable)            chk("proto_penable_needs_psel", 32'(bus.psel), 32'd1);
            if (bus.psel && prev_psel) begin
                chk("proto_paddr_stable",  bus.paddr,          prev_paddr);
                chk("proto_pwdata_stable", bus.pwdata,         prev_pwdata);
                chk("proto_pwrite_stable", 32'(bus.pwrite),    32'(prev_pwrite));
                chk("proto_pprot_stable",  32'(bus.pprot),     32'(prev_pprot));
            end
        end
        prev_psel   <= bus.psel;
        prev_paddr  <= bus.paddr;
        prev_pwdata <= bus.pwdata;
        prev_pwrite <= bus.pwrite;
        prev_pprot  <= bus.pprot;
    end

    initial begin
        tests = 0;
        fails = 0;
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        step();
        step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_psel",      32'(bus.psel),      32'd0);
        chk("rst_penable",   32'(bus.penable),   32'd0);
        chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_tmo",   32'(bus.rsp_tmo),   32'd0);
        chk("rst_paddr",     bus.paddr,          32'd0);
        chk("rst_pwdata",    bus.pwdata,         32'd0);
        chk("rst_pprot",     32'(bus.pprot),     32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        preset = 1'b0;
        step();
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Read, zero wait states
        bus.cmd_addr  = 32'h4000_0008;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h5555_5555;
        bus.cmd_prot  = 3'b101;
        bus.cmd_valid = 1'b1;
        bus.pready    = 1'b1;
        bus.prdata    = 32'hA5A5_1234;
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_c1_psel",      32'(bus.psel),      32'd1);
        chk("rd_c1_penable",   32'(bus.penable),   32'd0);
        chk("rd_c1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rd_c1_paddr",     bus.paddr,          32'h4000_0008);
        chk("rd_c1_pprot",     32'(bus.pprot),     32'd5);
        chk("rd_c1_pwrite",    32'(bus.pwrite),    32'd0);
        step();
        chk("rd_c2_psel",      32'(bus.psel),      32'd1);
        chk("rd_c2_penable",   32'(bus.penable),   32'd1);
        chk("rd_c2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("rd_c3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_c3_rdata",     bus.rsp_rdata,      32'hA5A5_1234);
        chk("rd_c3_err",       32'(bus.rsp_err),   32'd0);
        chk("rd_c3_tmo",       32'(bus.rsp_tmo),   32'd0);
        chk("rd_c3_psel",      32'(bus.psel),      32'd0);
        chk("rd_c3_penable",   32'(bus.penable),   32'd0);
        chk("rd_c3_paddr_kept", bus.paddr,         32'h4000_0008);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rd_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rd_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Write, 3 wait states, pslverr on completion (completion lands on the timeout threshold)
        bus.cmd_addr  = 32'h4000_0010;
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 32'hDEAD_BEEF;
        bus.cmd_prot  = 3'b010;
        bus.cmd_valid = 1'b1;
        bus.pready    = 1'b0;
        bus.prdata    = 32'h1111_2222;
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_setup_psel",    32'(bus.psel),    32'd1);
        chk("wr_setup_penable", 32'(bus.penable), 32'd0);
        chk("wr_setup_pwrite",  32'(bus.pwrite),  32'd1);
        chk("wr_setup_pwdata",  bus.pwdata,       32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin
                bus.pready  = 1'b1;
                bus.pslverr = 1'b1;
            end
            chk("wr_access_penable",   32'(bus.penable),   32'd1);
            chk("wr_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        step();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_err",   32'(bus.rsp_err),   32'd1);
        chk("wr_rsp_tmo",   32'(bus.rsp_tmo),   32'd0);
        chk("wr_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("wr_rsp_psel",  32'(bus.psel),      32'd0);
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("wr_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Timeout: pready held low for TMO_CYC=4 ACCESS cycles
        bus.cmd_addr  = 32'h4000_0020;
        bus.cmd_write = 1'b0;
        bus.cmd_prot  = 3'b000;
        bus.cmd_valid = 1'b1;
        bus.prdata    = 32'hFFFF_FFFF;
        step();
        bus.cmd_valid = 1'b0;
        chk("tmo_setup_psel", 32'(bus.psel), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tmo_access_penable", 32'(bus.penable), 32'd1);
        end
        step();
        chk("tmo_psel",      32'(bus.psel),      32'd0);
        chk("tmo_penable",   32'(bus.penable),   32'd0);
        chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("tmo_rsp_err",   32'(bus.rsp_err),   32'd1);
        chk("tmo_rsp_tmo",   32'(bus.rsp_tmo),   32'd1);
        chk("tmo_rsp_rdata", bus.rsp_rdata,      32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("tmo_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Response backpressure with a new command pending
        bus.cmd_addr  = 32'h4000_0030;
        bus.cmd_write = 1'b0;
        bus.cmd_prot  = 3'b001;
        bus.cmd_valid = 1'b1;
        bus.pready    = 1'b1;
        bus.prdata    = 32'h0BAD_F00D;
        step();
        bus.cmd_addr  = 32'h4000_0040;
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 32'h1234_5678;
        bus.cmd_prot  = 3'b111;
        step();
        chk("bp_access_paddr", bus.paddr, 32'h4000_0030);
        step();
        for (int i = 0; i < 5; i++) begin
            bus.prdata = 32'hCAFE_0000 + i;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata,      32'h0BAD_F00D);
            chk("bp_rsp_err",   32'(bus.rsp_err),   32'd0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_psel",      32'(bus.psel),      32'd0);
            step();
        end
        chk("bp_still_resp", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_idle_psel",      32'(bus.psel),      32'd0);
        step();
        bus.cmd_valid = 1'b0;
        chk("bp2_setup_psel",    32'(bus.psel),    32'd1);
        chk("bp2_setup_penable", 32'(bus.penable), 32'd0);
        chk("bp2_setup_paddr",   bus.paddr,        32'h4000_0040);
        chk("bp2_setup_pwrite",  32'(bus.pwrite),  32'd1);
        chk("bp2_setup_pwdata",  bus.pwdata,       32'h1234_5678);
        chk("bp2_setup_pprot",   32'(bus.pprot),   32'd7);
        step();
        step();
        chk("bp2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp2_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("bp2_rsp_err",   32'(bus.rsp_err),   32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // Reset asserted in ACCESS
        bus.cmd_addr  = 32'h4000_0050;
        bus.cmd_write = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.pready    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rsta_access_penable", 32'(bus.penable), 32'd1);
        preset = 1'b1;
        #1;
        chk("rsta_async_psel",    32'(bus.psel),    32'd0);
        chk("rsta_async_penable", 32'(bus.penable), 32'd0);
        step();
        preset = 1'b0;
        step();
        chk("rsta_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rsta_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rsta_psel",      32'(bus.psel),      32'd0);
        chk("rsta_paddr",     bus.paddr,          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
